dmem_access_ctrl: RTL and testbench

- Load/store sequencer sitting directly upstream of the data memory; it accepts one CPU memory request at a time and drives the memory's read/write/address/data pins.
- Converts byte addresses into word indices.
- Performs sub-word stores as word-wide read-modify-write. The memory therefore always sees full-word writes with store format 2'b00.
- Sign- or zero-extends load results and returns them with a one-cycle done pulse.

---
 rtl/dmem_access_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store sequencer in front of a word-addressed data memory.
// It takes one CPU request at a time. Byte addresses become word indices.
// Sub-word stores run as read-modify-write, so the memory only ever sees full-word writes.
// Build option DMEM_ALIGN_CHECK_EN: a misaligned request finishes at once with err=1
// and touches no memory. Without it, err is tied low and misaligned low bits are ignored.
//
// state    | meaning
// IDLE     | waiting for a request, ready high
// ACCESS   | single memory cycle: load read, sw write, or read of the word to merge
// MERGE_WR | write back the merged word for sh/sb
// DONE     | one-cycle done pulse, load_data/err valid
module dmem_access_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          DM_AW     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             ready,
  input  logic [2:0]       mem_op,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             done,
  output logic [31:0]      load_data,
  output logic             err,
  output logic             dm_r,
  output logic             dm_w,
  output logic [1:0]       store_format_signal,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_MERGE_WR = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] load_data_q, load_data_d;

  logic [31:0] off_q;
  logic        is_load_q;
  logic        accept;
  logic        dm_r_raw;
  logic        dm_w_raw;
  logic [31:0] dm_wdata_raw;
  logic        unused_off_hi;

  // Pick the addressed lane out of a read word and extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed byte or halfword of the captured word with store data.
  function automatic logic [31:0] merge_store(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] old_w, input logic [31:0] wd);
    logic [31:0] m;
    m = old_w;
    if (op == OP_SB) begin
      case (off)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (off[1]) begin
      m[31:16] = wd[15:0];
    end else begin
      m[15:0] = wd[15:0];
    end
    return m;
  endfunction

  assign off_q         = addr_q - BASE_ADDR;
  assign unused_off_hi = ^off_q[31:DM_AW+2];
  assign is_load_q     = (op_q <= OP_LBU);
  assign ready         = (state_q == ST_IDLE) && !rst;
  assign accept        = req && ready;

`ifdef DMEM_ALIGN_CHECK_EN
  logic        err_q, err_d;
  logic [31:0] off_in;
  logic        misaligned_in;
  logic        unused_off_in_hi;

  assign off_in           = addr - BASE_ADDR;
  assign unused_off_in_hi = ^off_in[31:2];

  // Alignment of the incoming request, judged on the offset from BASE_ADDR.
  always_comb begin
    misaligned_in = 1'b0;
    case (mem_op)
      OP_LW, OP_SW:         misaligned_in = (off_in[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned_in = off_in[0];
      default:              misaligned_in = 1'b0;
    endcase
  end

  // err is re-evaluated on every acceptance and held until the next one.
  always_comb begin
    err_d = err_q;
    if (accept) err_d = misaligned_in;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state and memory-pin decode; every target defaults to hold or idle.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    load_data_d  = load_data_q;
    dm_r_raw     = 1'b0;
    dm_w_raw     = 1'b0;
    dm_wdata_raw = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = mem_op;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = ST_ACCESS;
`ifdef DMEM_ALIGN_CHECK_EN
          if (misaligned_in) begin
            load_data_d = 32'h0;
            state_d     = ST_DONE;
          end
`endif
        end
      end
      ST_ACCESS: begin
        if (is_load_q) begin
          dm_r_raw    = 1'b1;
          load_data_d = extend_load(op_q, off_q[1:0], dm_rdata);
          state_d     = ST_DONE;
        end else if (op_q == OP_SW) begin
          dm_w_raw     = 1'b1;
          dm_wdata_raw = wdata_q;
          state_d      = ST_DONE;
        end else begin
          dm_r_raw = 1'b1;
          merge_d  = dm_rdata;
          state_d  = ST_MERGE_WR;
        end
      end
      ST_MERGE_WR: begin
        dm_w_raw     = 1'b1;
        dm_wdata_raw = merge_store(op_q, off_q[1:0], merge_q, wdata_q);
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request and result registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      merge_q     <= 32'h0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      merge_q     <= merge_d;
      load_data_q <= load_data_d;
    end
  end

  // Memory pins are forced quiet while reset is high so no write can slip through.
  assign dm_r                = dm_r_raw && !rst;
  assign dm_w                = dm_w_raw && !rst;
  assign dm_wdata            = rst ? 32'h0 : dm_wdata_raw;
  assign dm_addr             = rst ? '0 : off_q[DM_AW+1:2];
  assign store_format_signal = 2'b00;
  assign done                = (state_q == ST_DONE) && !rst;
  assign load_data           = load_data_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed requests, expected responses queued at issue time
// and checked by an independent monitor whenever done or dm_w appears.
module tb_dmem_access_ctrl;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          AW   = 11;

  localparam logic [2:0] LW  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LHU = 3'b010;
  localparam logic [2:0] LB  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] SW  = 3'b101;
  localparam logic [2:0] SH  = 3'b110;
  localparam logic [2:0] SB  = 3'b111;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          ready;
  logic [2:0]    mem_op;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          done;
  logic [31:0]   load_data;
  logic          err;
  logic          dm_r;
  logic          dm_w;
  logic [1:0]    sfs;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [31:0]   pre_d;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic        err;
    int          lat;
  } exp_done_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            lat;
  } exp_wr_t;

  exp_done_t dq[$];
  exp_wr_t   wq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_done = -100;
  int last_gap = 0;
  int dm_r_cnt = 0;

  dmem_access_ctrl #(.BASE_ADDR(BASE), .DM_AW(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req                 (req),
    .ready               (ready),
    .mem_op              (mem_op),
    .addr                (addr),
    .wdata               (wdata),
    .done                (done),
    .load_data           (load_data),
    .err                 (err),
    .dm_r                (dm_r),
    .dm_w                (dm_w),
    .store_format_signal (sfs),
    .dm_addr             (dm_addr),
    .dm_wdata            (dm_wdata),
    .dm_rdata            (dm_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: bench preload port, otherwise DUT writes.
  always @(posedge clk) begin
    if (pre_we)    mem[pre_a] <= pre_d;
    else if (dm_w) mem[dm_addr] <= dm_wdata;
  end

  assign dm_rdata = mem[dm_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_done(input logic [31:0] d, input logic c, input logic e, input int l);
    exp_done_t x;
    x.data = d; x.chk_data = c; x.err = e; x.lat = l;
    dq.push_back(x);
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d, input int l);
    exp_wr_t x;
    x.a = a; x.d = d; x.lat = l;
    wq.push_back(x);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: ready stayed %b, expected 1", ready);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    mem_op = op; addr = a; wdata = wd; req = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((dq.size() != 0 || wq.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (dq.size() != 0 || wq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL response_timeout: %0d done and %0d writes outstanding, expected 0",
               dq.size(), wq.size());
      dq.delete(); wq.delete();
    end
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] exp);
    expect_done(exp, 1'b1, 1'b0, 2);
    issue(op, a, 32'h0);
    wait_idle();
  endtask

  // Monitor: sample away from the rising edge and score every done / write.
  initial begin
    exp_done_t e;
    exp_wr_t   w;
    forever begin
      @(negedge clk);
      if (dm_r) dm_r_cnt++;
      if (req && ready) begin
        last_gap = cyc - last_done;
        acc_cyc  = cyc;
      end
      if (dm_w) begin
        if (wq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: dm_w=1 addr %h data %h, expected no write", dm_addr, dm_wdata);
        end else begin
          w = wq.pop_front();
          check("wr_addr", 32'(dm_addr), 32'(w.a));
          check("wr_data", dm_wdata, w.d);
          check("wr_latency", cyc - acc_cyc, w.lat);
          check("wr_format", 32'(sfs), 32'h0);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: done=1 load_data %h, expected no done", load_data);
        end else begin
          e = dq.pop_front();
          if (e.chk_data) check("load_data", load_data, e.data);
          check("err", 32'(err), 32'(e.err));
          check("done_latency", cyc - acc_cyc, e.lat);
        end
        last_done = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst = 1'b1; req = 1'b0; mem_op = 3'b000; addr = 32'h0; wdata = 32'h0;
    pre_we = 1'b0; pre_a = '0; pre_d = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_dm_r", 32'(dm_r), 32'h0);
    check("rst_dm_w", 32'(dm_w), 32'h0);
    check("rst_dm_wdata", dm_wdata, 32'h0);
    check("rst_dm_addr", 32'(dm_addr), 32'h0);

    preload(11'd3, 32'h8899_AABB);
    preload(11'd0, 32'h0102_0304);
    preload(11'd1, 32'h0000_0000);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(ready), 32'h1);

    // Loads from word 3 = 8899_AABB
    do_load(LB,  BASE + 32'd13, 32'hFFFF_FFAA);
    do_load(LB,  BASE + 32'd14, 32'hFFFF_FF99);
    do_load(LHU, BASE + 32'd14, 32'h0000_8899);
    do_load(LH,  BASE + 32'd12, 32'hFFFF_AABB);
    do_load(LBU, BASE + 32'd15, 32'h0000_0088);
    do_load(LW,  BASE + 32'd12, 32'h8899_AABB);

    // sb lane 1: AA -> 77
    expect_wr(11'd3, 32'h8899_77BB, 2);
    expect_done(32'h0, 1'b0, 1'b0, 3);
    issue(SB, BASE + 32'd13, 32'h1234_5677);
    wait_idle();
    do_load(LW, BASE + 32'd12, 32'h8899_77BB);

    // sh upper half
    expect_wr(11'd3, 32'hCAFE_77BB, 2);
    expect_done(32'h0, 1'b0, 1'b0, 3);
    issue(SH, BASE + 32'd14, 32'h0000_CAFE);
    wait_idle();

    // sw then lw with req held high; inputs change right after the first acceptance
    expect_wr(11'd1, 32'hDEAD_BEEF, 1);
    expect_done(32'h0, 1'b0, 1'b0, 2);
    expect_done(32'hDEAD_BEEF, 1'b1, 1'b0, 2);
    @(posedge clk); #1;
    mem_op = SW; addr = BASE + 32'd4; wdata = 32'hDEAD_BEEF; req = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    mem_op = LW; addr = BASE + 32'd4; wdata = 32'h0;
    wait_accept();
    @(posedge clk); #1;
    req = 1'b0;
    check("b2b_accept_gap", last_gap, 32'd1);
    wait_idle();

    // Reset during the MERGE_WR cycle of an sh: no write, no done
    @(posedge clk); #1;
    mem_op = SH; addr = BASE + 32'd12; wdata = 32'h0000_1111; req = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_dm_w", 32'(dm_w), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'h1);
    check("abort_mem_word", mem[3], 32'hCAFE_77BB);
    repeat (3) @(negedge clk);

    // Misaligned lw at BASE+2
    r0 = dm_r_cnt;
`ifdef DMEM_ALIGN_CHECK_EN
    expect_done(32'h0, 1'b1, 1'b1, 1);
`else
    expect_done(32'h0102_0304, 1'b1, 1'b0, 2);
`endif
    issue(LW, BASE + 32'd2, 32'h0);
    wait_idle();
`ifdef DMEM_ALIGN_CHECK_EN
    check("misalign_lw_dm_r_cycles", dm_r_cnt - r0, 32'd0);
`else
    check("misalign_lw_dm_r_cycles", dm_r_cnt - r0, 32'd1);
`endif

    // Misaligned lh at BASE+13 (word 3 = CAFE_77BB)
`ifdef DMEM_ALIGN_CHECK_EN
    expect_done(32'h0, 1'b1, 1'b1, 1);
`else
    expect_done(32'h0000_77BB, 1'b1, 1'b0, 2);
`endif
    issue(LH, BASE + 32'd13, 32'h0);
    wait_idle();

    // Next acceptance clears err
    do_load(LW, BASE + 32'd12, 32'hCAFE_77BB);

    // sb lane 0 then read back
    expect_wr(11'd3, 32'hCAFE_775A, 2);
    expect_done(32'h0, 1'b0, 1'b0, 3);
    issue(SB, BASE + 32'd12, 32'hFFFF_FF5A);
    wait_idle();
    do_load(LB, BASE + 32'd12, 32'h0000_005A);
    do_load(LW, BASE + 32'd12, 32'hCAFE_775A);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
